// File: rtl/sync_deser_pkg.sv
// Shared types and constants for the sync-word frame deserialiser.
// SYNC_DESER_PARITY_EN adds a per-word even-parity sub-phase.
package sync_deser_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      DATA = 1'b1
   } state_t;

`ifdef SYNC_DESER_PARITY_EN
   localparam logic PARITY_PHASE = 1'b1;
`else
   localparam logic PARITY_PHASE = 1'b0;
`endif

   localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

   // Bits needed to hold every value from 0 up to and including max_val.
   function automatic int bits_for(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sync_frame_deser_shift.sv
// W-bit MSB-first shift-in register with enable and synchronous clear.
module ser_shift_in #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic         din,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= {q[W-2:0], din};
      end
   end

endmodule

// File: rtl/sync_frame_deser.sv
// Hunts for a sync word on a qualified serial stream, then deserialises one frame of words.
// Define SYNC_DESER_PARITY_EN to expect an even-parity bit after every data word.
module sync_frame_deser
   import sync_deser_pkg::*;
#(
   parameter int                DATA_W      = 8,
   parameter int                SYNC_W      = 8,
   parameter logic [SYNC_W-1:0] SYNC_WORD   = SYNC_W'(DEFAULT_SYNC_WORD),
   parameter int                FRAME_WORDS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  logic              bit_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              frame_start,
   output logic              frame_end,
   output logic              locked,
   output logic              parity_err
);

   localparam int BCW = bits_for(DATA_W);
   localparam int WCW = $clog2(FRAME_WORDS) + 1;
   localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_W - 1);
   localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);

   state_t            state;
   logic [BCW-1:0]    bit_cnt;
   logic [WCW-1:0]    word_cnt;
   logic              word_rdy;
   logic [SYNC_W-1:0] sync_q;
   logic [DATA_W-1:0] data_q;
   logic              sync_hit;
   logic              frame_over;
   logic              sync_en;
   logic              sync_clr;
   logic              data_en;

   // Match on the value the sync register is about to take, so lock follows the matching bit directly.
   assign sync_hit = ({sync_q[SYNC_W-2:0], din} == SYNC_WORD);
   assign sync_en  = bit_en && (state == HUNT);
   assign locked   = (state == DATA);

`ifdef SYNC_DESER_PARITY_EN
   logic in_par;
   logic par_fail;

   assign frame_over = (word_rdy && (word_cnt == LAST_WORD)) || par_fail;
   assign data_en    = bit_en && (state == DATA) && !in_par && !frame_over;
`else
   assign frame_over = word_rdy && (word_cnt == LAST_WORD);
   assign data_en    = bit_en && (state == DATA) && !frame_over;
   assign parity_err = 1'b0;
`endif

   // A frame leaves DATA with an empty sync register so data bits can never complete a sync.
   assign sync_clr = rst || ((state == DATA) && frame_over);

   ser_shift_in #(.W(SYNC_W)) u_sync_sr (
      .clk (clk),
      .clr (sync_clr),
      .en  (sync_en),
      .din (din),
      .q   (sync_q)
   );

   ser_shift_in #(.W(DATA_W)) u_data_sr (
      .clk (clk),
      .clr (rst),
      .en  (data_en),
      .din (din),
      .q   (data_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= HUNT;
         bit_cnt     <= '0;
         word_cnt    <= '0;
         word_rdy    <= 1'b0;
         dout        <= '0;
         dout_valid  <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
`ifdef SYNC_DESER_PARITY_EN
         in_par      <= 1'b0;
         par_fail    <= 1'b0;
         parity_err  <= 1'b0;
`endif
      end else begin
         dout_valid  <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         word_rdy    <= 1'b0;
`ifdef SYNC_DESER_PARITY_EN
         par_fail    <= 1'b0;
         parity_err  <= 1'b0;
`endif
         if (state == HUNT) begin
            if (sync_en && sync_hit) begin
               state    <= DATA;
               bit_cnt  <= '0;
               word_cnt <= '0;
            end
         end else begin
            if (data_en) begin
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= '0;
`ifdef SYNC_DESER_PARITY_EN
                  in_par  <= PARITY_PHASE;
`else
                  word_rdy <= 1'b1;
`endif
               end else begin
                  bit_cnt <= bit_cnt + BCW'(1);
               end
            end
`ifdef SYNC_DESER_PARITY_EN
            // Word bits XOR parity bit must be zero; a bad word aborts the whole frame.
            if (in_par && bit_en) begin
               in_par <= 1'b0;
               if (^{data_q, din}) begin
                  par_fail <= 1'b1;
               end else begin
                  word_rdy <= 1'b1;
               end
            end
            if (par_fail) begin
               parity_err <= 1'b1;
               state      <= HUNT;
               word_cnt   <= '0;
            end
`endif
            // Publish one cycle after the completing bit; the next word may already be shifting in.
            if (word_rdy) begin
               dout        <= data_q;
               dout_valid  <= 1'b1;
               frame_start <= (word_cnt == '0);
               frame_end   <= (word_cnt == LAST_WORD);
               if (word_cnt == LAST_WORD) begin
                  state    <= HUNT;
                  word_cnt <= '0;
               end else begin
                  word_cnt <= word_cnt + WCW'(1);
               end
            end
         end
      end
   end

endmodule
